// File: rtl/serial_to_parallel.sv
// Collects an enable-qualified serial bit stream into WIDTH-bit words and
// presents each finished word on a registered output with a one-cycle strobe.
module serial_to_parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             dat_en,
  output logic [WIDTH-1:0] po,
  output logic             dat_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;

  // sr_shift is the word as it would stand after this edge's si is taken in
  generate
    if (WIDTH == 1) begin : g_w1
      assign sr_shift = si;
    end else if (MSB_FIRST) begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], si};
    end else begin : g_lsb
      assign sr_shift = {si, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
    valid_d = 1'b0;
    if (dat_en) begin
      sr_d = sr_shift;
      if (cnt_q == CNT_LAST) begin
        po_d    = sr_shift;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      // Dropping the enable discards the partial word and re-frames.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      valid_q <= valid_d;
    end
  end

  assign po        = po_q;
  assign dat_valid = valid_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: three instances (4-bit MSB-first,
// 4-bit LSB-first, 8-bit MSB-first) share one stimulus stream.
module tb_serial_to_parallel;

  localparam int NDUT = 3;
  localparam int W   [NDUT] = '{4, 4, 8};
  localparam bit MSB [NDUT] = '{1'b1, 1'b0, 1'b1};

  logic clk;
  logic rst_n;
  logic si;
  logic dat_en;

  logic [3:0] po0, po1;
  logic [7:0] po2;
  logic       v0, v1, v2;

  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
    .clk(clk), .rst_n(rst_n), .si(si), .dat_en(dat_en), .po(po0), .dat_valid(v0));
  serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
    .clk(clk), .rst_n(rst_n), .si(si), .dat_en(dat_en), .po(po1), .dat_valid(v1));
  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8_msb (
    .clk(clk), .rst_n(rst_n), .si(si), .dat_en(dat_en), .po(po2), .dat_valid(v2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Reference model: bits of the word in progress, completed words awaiting
  // their strobe, and the word po should currently hold.
  bit         part_q [NDUT][$];
  logic [7:0] exp_q  [NDUT][$];
  logic [7:0] exp_po [NDUT];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] assemble(input int d);
    int unsigned word = 0;
    for (int k = 0; k < W[d]; k++)
      if (part_q[d][k]) word += MSB[d] ? (1 << (W[d] - 1 - k)) : (1 << k);
    return 8'(word);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit s);
    for (int d = 0; d < NDUT; d++) begin
      if (!r) begin
        part_q[d].delete();
        exp_q[d].delete();
        exp_po[d] = 8'h00;
      end else if (!e) begin
        part_q[d].delete();
      end else begin
        part_q[d].push_back(s);
        if (part_q[d].size() == W[d]) begin
          exp_po[d] = assemble(d);
          exp_q[d].push_back(exp_po[d]);
          part_q[d].delete();
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit s);
    rst_n  = r;
    dat_en = e;
    si     = s;
    @(posedge clk);
    model_edge(r, e, s);
    #2;
  endtask

  task automatic send_bits(input int n, input logic [7:0] bits_msb_first);
    logic [7:0] b;
    b = bits_msb_first;
    for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, b[i]);
  endtask

  // Monitor: every cycle, a strobe must match the head of the queue and po
  // must equal the model's held word; a pending word with no strobe is a miss.
  always @(negedge clk) begin
    logic [7:0] act_po [NDUT];
    logic       act_v  [NDUT];
    logic [7:0] w;
    if (mon_en) begin
      act_po[0] = {4'h0, po0}; act_v[0] = v0;
      act_po[1] = {4'h0, po1}; act_v[1] = v1;
      act_po[2] = po2;         act_v[2] = v2;
      for (int d = 0; d < NDUT; d++) begin
        if (act_v[d] === 1'b1) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("spurious_valid_dut%0d", d), {7'h0, act_v[d]}, 8'h00);
          end else begin
            w = exp_q[d].pop_front();
            chk($sformatf("word_dut%0d", d), act_po[d], w);
          end
        end else begin
          if (exp_q[d].size() != 0) begin
            void'(exp_q[d].pop_front());
            chk($sformatf("missing_valid_dut%0d", d), {7'h0, act_v[d]}, 8'h01);
          end
        end
        chk($sformatf("po_hold_dut%0d", d), act_po[d], exp_po[d]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) exp_po[d] = 8'h00;
    rst_n = 1'b0; dat_en = 1'b0; si = 1'b0;

    drive(1'b0, 1'b1, 1'b1);
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, i[0]);
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset_po_w4", {4'h0, po0}, 8'h00);
    chk("reset_valid_w4", {7'h0, v0}, 8'h00);
    chk("reset_po_w8", po2, 8'h00);

    // Continuous stream 1010 0101 0011 1100.
    send_bits(4, 8'h0A); send_bits(4, 8'h05);
    send_bits(4, 8'h03); send_bits(4, 8'h0C);
    @(negedge clk);
    chk("stream_last_word", {4'h0, po0}, 8'h0C);
    chk("stream_last_valid", {7'h0, v0}, 8'h01);

    // Enable low: si toggles, nothing moves.
    begin
      logic [11:0] pat;
      pat = 12'b111001001001;
      for (int i = 11; i >= 0; i--) drive(1'b1, 1'b0, pat[i]);
    end
    @(negedge clk);
    chk("en_low_hold", {4'h0, po0}, 8'h0C);
    chk("en_low_no_valid", {7'h0, v0}, 8'h00);

    // Mid-word abort.
    send_bits(2, 8'h03);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(4, 8'h06);
    @(negedge clk);
    chk("abort_word", {4'h0, po0}, 8'h06);
    drive(1'b1, 1'b0, 1'b0);

    // Reset mid-word.
    send_bits(3, 8'h07);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("midword_reset_po", {4'h0, po0}, 8'h00);
    send_bits(4, 8'h09);
    @(negedge clk);
    chk("post_reset_word", {4'h0, po0}, 8'h09);
    drive(1'b1, 1'b0, 1'b0);

    // LSB-first 1,0,0,0 on the 4-bit LSB instance.
    send_bits(4, 8'h08);
    @(negedge clk);
    chk("lsb_first_word", {4'h0, po1}, 8'h01);
    drive(1'b1, 1'b0, 1'b0);

    // 8-bit word 1,0,1,1,0,0,1,0.
    send_bits(8, 8'hB2);
    @(negedge clk);
    chk("w8_word", po2, 8'hB2);
    chk("w8_valid", {7'h0, v2}, 8'h01);

    // Reset on the edge a word would complete.
    drive(1'b1, 1'b0, 1'b0);
    send_bits(3, 8'h05);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("reset_wins_po", {4'h0, po0}, 8'h00);
    chk("reset_wins_valid", {7'h0, v0}, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0), 1'($urandom));

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("drain_dut%0d", d), 8'(exp_q[d].size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
